// File: rtl/run_length_word_gen.sv
`default_nettype none
// ============================================================================
// Module   : run_length_word_gen
// Purpose  : Builds the canonical word whose LSB-first run has a given length.
//            Optional macro RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN adds a sticky err
//            output and drops counts above DATA_WIDTH instead of clamping them.
// Revision : 1.0 - initial release
// ============================================================================
module run_length_word_gen #(
    parameter int DATA_WIDTH = 16,
    parameter bit COUNT_ZERO = 1'b1,
    parameter bit FILL       = 1'b0,
    parameter bit PIPELINED  = 1'b1,
    localparam int CNT_BIT   = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CNT_BIT-1:0]    in_cnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] out_mask,
    output logic [CNT_BIT-1:0]    out_cnt
`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int                    c_NST = PIPELINED ? CNT_BIT : 1;
    localparam logic [CNT_BIT-1:0]    c_DW  = CNT_BIT'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_ONE = DATA_WIDTH'(1);

    // Count bit k contributes 2**k run positions, placed above the runs of all higher bits.
    function automatic logic [DATA_WIDTH-1:0] f_resolve(
        input logic [DATA_WIDTH-1:0] m,
        input logic [CNT_BIT-1:0]    cnt,
        input int                    hi,
        input int                    lo
    );
        logic [DATA_WIDTH-1:0] r;
        logic [DATA_WIDTH-1:0] run;
        logic [CNT_BIT-1:0]    off;
        r = m;
        for (int k = 0; k < CNT_BIT; k++) begin
            off = (cnt >> (k + 1)) << (k + 1);
            run = (c_ONE << (1 << k)) - c_ONE;
            if (k >= lo && k <= hi && cnt[k]) begin
                r = r | (run << off);
            end
        end
        return r;
    endfunction

    // mask+1 is the terminator bit; it wraps to zero for a full-width run.
    function automatic logic [DATA_WIDTH-1:0] f_word(input logic [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] term;
        logic [DATA_WIDTH-1:0] above;
        term  = m + c_ONE;
        above = FILL ? ~(m | term) : '0;
        return (COUNT_ZERO ? term : m) | above;
    endfunction

    logic [c_NST:0]        stage_ready;
    logic [c_NST-1:0]      stage_valid;
    logic [CNT_BIT-1:0]    stage_cnt  [c_NST];
    logic [DATA_WIDTH-1:0] stage_mask [c_NST];
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_BIT-1:0]    cnt_clamped;
    logic                  in_ok;

    assign cnt_clamped = (in_cnt > c_DW) ? c_DW : in_cnt;

`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
    logic err_q;

    assign in_ok = (in_cnt <= c_DW);
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (in_valid && in_ready && !in_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    assign in_ok = 1'b1;
`endif

    assign stage_ready[c_NST] = out_ready;
    assign in_ready           = stage_ready[0];

    generate
        for (genvar s = 0; s < c_NST; s++) begin : g_stage
            localparam int c_HI = PIPELINED ? (CNT_BIT - 1 - s) : (CNT_BIT - 1);
            localparam int c_LO = PIPELINED ? (CNT_BIT - 1 - s) : 0;

            logic                  v_in;
            logic [CNT_BIT-1:0]    c_in;
            logic [DATA_WIDTH-1:0] m_in;
            logic [DATA_WIDTH-1:0] mask_d;
            logic                  valid_q;
            logic [CNT_BIT-1:0]    cnt_q;
            logic [DATA_WIDTH-1:0] mask_q;

            if (s == 0) begin : g_head
                assign v_in = in_valid & in_ok;
                assign c_in = cnt_clamped;
                assign m_in = '0;
            end else begin : g_body
                assign v_in = stage_valid[s-1];
                assign c_in = stage_cnt[s-1];
                assign m_in = stage_mask[s-1];
            end

            assign mask_d         = f_resolve(m_in, c_in, c_HI, c_LO);
            assign stage_ready[s] = ~valid_q | stage_ready[s+1];
            assign stage_valid[s] = valid_q;
            assign stage_cnt[s]   = cnt_q;
            assign stage_mask[s]  = mask_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                    mask_q  <= '0;
                end else if (stage_ready[s]) begin
                    valid_q <= v_in;
                    if (v_in) begin
                        cnt_q  <= c_in;
                        mask_q <= mask_d;
                    end
                end
            end

            if (s == c_NST - 1) begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        data_q <= '0;
                    end else if (stage_ready[s] && v_in) begin
                        data_q <= f_word(mask_d);
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stage_valid[c_NST-1];
    assign out_cnt   = stage_cnt[c_NST-1];
    assign out_mask  = stage_mask[c_NST-1];
    assign out_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_run_length_word_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_length_word_gen
// Purpose  : Directed and random checks of run_length_word_gen in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_length_word_gen;

    localparam int DW = 16;
    localparam int CB = 5;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [CB-1:0] in_cnt   = '0;

    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [DW-1:0] a_data, a_mask, b_data, b_mask, c_data, c_mask;
    logic [CB-1:0] a_cnt, b_cnt, c_cnt;
    logic          xfer_a;
`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
    logic          a_err, b_err, c_err;
`endif

    always #5 clk = ~clk;

    assign xfer_a = in_valid & a_in_ready;

    run_length_word_gen #(.DATA_WIDTH(DW), .COUNT_ZERO(1'b1), .FILL(1'b0), .PIPELINED(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_cnt(in_cnt),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_data), .out_mask(a_mask),
        .out_cnt(a_cnt)
`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
        , .err(a_err)
`endif
    );

    run_length_word_gen #(.DATA_WIDTH(DW), .COUNT_ZERO(1'b0), .FILL(1'b1), .PIPELINED(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(xfer_a), .in_ready(b_in_ready), .in_cnt(in_cnt),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_data), .out_mask(b_mask),
        .out_cnt(b_cnt)
`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
        , .err(b_err)
`endif
    );

    run_length_word_gen #(.DATA_WIDTH(DW), .COUNT_ZERO(1'b1), .FILL(1'b0), .PIPELINED(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(xfer_a), .in_ready(c_in_ready), .in_cnt(in_cnt),
        .out_valid(c_out_valid), .out_ready(1'b1), .out_data(c_data), .out_mask(c_mask),
        .out_cnt(c_cnt)
`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
        , .err(c_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_word(input int c, input bit cz, input bit fill);
        logic [DW-1:0] w;
        bit r;
        r = !cz;
        for (int i = 0; i < DW; i++) begin
            w[i] = (i < c) ? r : ((i == c) ? !r : fill);
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] model_mask(input int c);
        logic [DW-1:0] m;
        for (int i = 0; i < DW; i++) m[i] = (i < c);
        return m;
    endfunction

    function automatic int run_count(input logic [DW-1:0] w, input bit cz);
        for (int i = 0; i < DW; i++) begin
            if (w[i] != !cz) return i;
        end
        return DW;
    endfunction

    int            send_q[$];
    int            qa[$], qb[$], qc[$];
    logic [DW-1:0] a_log_data[$], a_log_mask[$], b_log_data[$], b_log_mask[$];
    int            a_log_cnt[$];
    bit            xfer_seen = 1'b0;
    bit            rand_rdy  = 1'b0;
    bit            err_exp   = 1'b0;
    bit            a_hold    = 1'b0;
    logic [DW-1:0] hold_data;
    logic [CB-1:0] hold_cnt;
    int            cyc = 0;
    int            accepted = 0;
    int            beats_a = 0;
    int            t_in = -1, t_out_a = -1, t_out_c = -1, t_last_a = -1;

    always @(posedge clk) cyc++;

    // Driver: presents the head of send_q and retires it once transferred.
    initial begin
        forever begin
            @(posedge clk);
            if (xfer_seen) void'(send_q.pop_front());
            #1;
            in_valid = (send_q.size() > 0);
            in_cnt   = in_valid ? CB'(send_q[0]) : '0;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scores beats of all three instances and records accepted counts.
    always @(negedge clk) begin
        int e;
        int v;
        xfer_seen = rst_n && in_valid && a_in_ready;
        if (!rst_n) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                check("a_hold_data", a_data, hold_data);
                check("a_hold_cnt", a_cnt, hold_cnt);
            end
            a_hold    = a_out_valid && !out_ready;
            hold_data = a_data;
            hold_cnt  = a_cnt;
            check("bc_in_ready", b_in_ready & c_in_ready, 1);
            if (a_out_valid && t_out_a < 0) t_out_a = cyc;
            if (c_out_valid && t_out_c < 0) t_out_c = cyc;
            if (a_out_valid && out_ready) begin
                check("a_beat_expected", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    check("a_data", a_data, model_word(e, 1'b1, 1'b0));
                    check("a_mask", a_mask, model_mask(e));
                    check("a_cnt", a_cnt, e);
                end
                check("a_roundtrip", run_count(a_data, 1'b1), a_cnt);
                a_log_data.push_back(a_data);
                a_log_mask.push_back(a_mask);
                a_log_cnt.push_back(int'(a_cnt));
                beats_a++;
                t_last_a = cyc;
            end
            if (b_out_valid) begin
                check("b_beat_expected", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    check("b_data", b_data, model_word(e, 1'b0, 1'b1));
                    check("b_mask", b_mask, model_mask(e));
                    check("b_cnt", b_cnt, e);
                end
                b_log_data.push_back(b_data);
                b_log_mask.push_back(b_mask);
            end
            if (c_out_valid) begin
                check("c_beat_expected", qc.size() > 0, 1);
                if (qc.size() > 0) begin
                    e = qc.pop_front();
                    check("c_data", c_data, model_word(e, 1'b1, 1'b0));
                    check("c_mask", c_mask, model_mask(e));
                    check("c_cnt", c_cnt, e);
                end
            end
`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
            check("err_a", a_err, err_exp);
            check("err_bc", b_err & c_err, err_exp);
`endif
            if (in_valid && a_in_ready) begin
                accepted++;
                if (t_in < 0) t_in = cyc;
                v = int'(in_cnt);
`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
                if (v > DW) begin
                    err_exp = 1'b1;
                end else begin
                    qa.push_back(v); qb.push_back(v); qc.push_back(v);
                end
`else
                if (v > DW) v = DW;
                qa.push_back(v); qb.push_back(v); qc.push_back(v);
`endif
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((send_q.size() != 0 || qa.size() != 0 || qb.size() != 0 || qc.size() != 0)
               && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < max_cyc, 1);
    endtask

    task automatic clear_logs();
        a_log_data.delete(); a_log_mask.delete(); a_log_cnt.delete();
        b_log_data.delete(); b_log_mask.delete();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        qa.delete(); qb.delete(); qc.delete();
        err_exp = 1'b0;
        rst_n   = 1'b1;
    endtask

    localparam logic [DW-1:0] T1_DATA [4] = '{16'h0001, 16'h0008, 16'h8000, 16'h0000};
    localparam logic [DW-1:0] T1_MASK [4] = '{16'h0000, 16'h0007, 16'h7FFF, 16'hFFFF};

    initial begin
        int base;
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_data, 0);
        check("rst_out_mask", a_mask, 0);
        check("rst_out_cnt", a_cnt, 0);
        check("rst_in_ready", a_in_ready, 1);

        // Back-to-back 0,3,15,16: latency and burst shape
        clear_logs();
        send_q = '{0, 3, 15, 16};
        wait_drain(60);
        check("lat_pipelined", t_out_a - t_in, 5);
        check("lat_single", t_out_c - t_in, 1);
        check("burst_beats", beats_a, 4);
        check("burst_span", t_last_a - t_out_a, 3);
        check("t1_count", a_log_data.size(), 4);
        for (int i = 0; i < 4 && i < a_log_data.size(); i++) begin
            check($sformatf("t1_data%0d", i), a_log_data[i], T1_DATA[i]);
            check($sformatf("t1_mask%0d", i), a_log_mask[i], T1_MASK[i]);
        end

        // Inverted polarity with FILL=1
        clear_logs();
        send_q = '{4, 16};
        wait_drain(60);
        check("b_count", b_log_data.size(), 2);
        if (b_log_data.size() == 2) begin
            check("b_data4", b_log_data[0], 16'hFFEF);
            check("b_mask4", b_log_mask[0], 16'h000F);
            check("b_data16", b_log_data[1], 16'hFFFF);
        end

        // Stall with out_ready low while streaming 1..8
        clear_logs();
        @(posedge clk); #1 out_ready = 1'b0;
        base = accepted;
        send_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        repeat (14) @(negedge clk);
        check("stall_accepts", accepted - base, 5);
        check("stall_in_ready", a_in_ready, 0);
        check("stall_out_valid", a_out_valid, 1);
        check("stall_out_data", a_data, 16'h0002);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain(80);
        check("stall_beats", a_log_cnt.size(), 8);
        for (int i = 0; i < 8 && i < a_log_cnt.size(); i++) begin
            check($sformatf("stall_order%0d", i), a_log_cnt[i], i + 1);
        end

        // Reset with three items in flight
        base = accepted;
        send_q = '{2, 7, 9};
        n = 0;
        while (accepted - base < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("inflight_timeout", n < 40, 1);
        pulse_reset();
        base = beats_a;
        @(negedge clk);
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_in_ready", a_in_ready, 1);
        repeat (12) @(negedge clk);
        check("midrst_no_stale", beats_a - base, 0);

        // Random counts with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) send_q.push_back(int'($urandom_range(0, DW)));
        wait_drain(60000);
        rand_rdy = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;

        // Out-of-range count followed by a legal one
        clear_logs();
        send_q = '{17, 5};
        wait_drain(60);
        repeat (4) @(negedge clk);
`ifdef RUN_LENGTH_WORD_GEN_RANGE_CHECK_EN
        check("range_beats", a_log_data.size(), 1);
        if (a_log_data.size() == 1) check("range_data5", a_log_data[0], 16'h0020);
        check("range_err", a_err, 1);
        pulse_reset();
        @(negedge clk);
        check("range_err_cleared", a_err, 0);
`else
        check("range_beats", a_log_data.size(), 2);
        if (a_log_data.size() == 2) begin
            check("range_data17", a_log_data[0], 16'h0000);
            check("range_cnt17", a_log_cnt[0], 16);
            check("range_data5", a_log_data[1], 16'h0020);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
